// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch/jump flush and optional debug halt/step sequencing (debug under HAZARD_DBG_EN)
module hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsAddr_id,
    input  logic [4:0]       RtAddr_id,
    input  logic             RsRead_id,
    input  logic             RtRead_id,
    input  logic             Jump_id,
    input  logic             MemRead_ex,
    input  logic [4:0]       RegWriteAddr_ex,
    input  logic             BranchTaken_ex,
    input  logic             dbg_halt,
    input  logic             dbg_run,
    input  logic             dbg_step,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             PipeEn,
    output logic             Halted,
    output logic [CNT_W-1:0] AdvCnt
);
    typedef enum logic [1:0] {RUN, LSTALL, HALT, STEP} state_t;
    localparam bit         MULTI     = (LOAD_STALL_CYC > 1);
    localparam logic [1:0] SCNT_INIT = 2'(LOAD_STALL_CYC - 2);
    state_t           state_q, state_d;
    logic [1:0]       scnt_q, scnt_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] adv_cnt_q, adv_cnt_d;
    logic             halt_req, run_req, step_req, hazard, hp;
`ifdef HAZARD_DBG_EN
    assign halt_req = dbg_halt;
    assign run_req  = dbg_run;
    assign step_req = dbg_step;
`else
    logic unused_dbg;
    assign unused_dbg = dbg_halt ^ dbg_run ^ dbg_step;
    assign halt_req   = 1'b0;
    assign run_req    = 1'b0;
    assign step_req   = 1'b0;
`endif
    assign hazard = MemRead_ex && RegWriteAddr_ex != 5'd0 &&
                    ((RsRead_id && RsAddr_id == RegWriteAddr_ex) ||
                     (RtRead_id && RtAddr_id == RegWriteAddr_ex));
    assign hp     = halt_pend_q | halt_req;
    assign Halted = (state_q == HALT);
    assign AdvCnt = adv_cnt_q;
    // Strobe priority (branch > hazard > jump) and next-state sequencing
    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        halt_pend_d = halt_pend_q;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        PipeEn      = 1'b1;
        case (state_q)
            RUN, STEP: begin
                if (BranchTaken_ex) begin
                    IFIDFlush = 1'b1;
                    IDEXFlush = 1'b1;
                end else if (hazard) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEXFlush = 1'b1;
                end else if (Jump_id) begin
                    IFIDFlush = 1'b1;
                end
                if (!BranchTaken_ex && hazard && MULTI) begin
                    state_d     = LSTALL;
                    scnt_d      = SCNT_INIT;
                    halt_pend_d = (state_q == STEP) | halt_req;
                end else begin
                    state_d = (state_q == STEP || halt_req) ? HALT : RUN;
                end
            end
            LSTALL: begin
                PCWrite   = BranchTaken_ex;
                IFIDWrite = BranchTaken_ex;
                IFIDFlush = BranchTaken_ex;
                IDEXFlush = 1'b1;
                if (BranchTaken_ex || scnt_q == 2'd0) begin
                    state_d     = hp ? HALT : RUN;
                    scnt_d      = 2'd0;
                    halt_pend_d = 1'b0;
                end else begin
                    scnt_d      = scnt_q - 2'd1;
                    halt_pend_d = hp;
                end
            end
            default: begin
                PipeEn    = 1'b0;
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                state_d   = step_req ? STEP : (run_req && !halt_req) ? RUN : HALT;
            end
        endcase
        adv_cnt_d = adv_cnt_q + {{(CNT_W-1){1'b0}}, PipeEn & PCWrite};
    end
    // State, stall counter, pending halt and advance counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            scnt_q      <= 2'd0;
            halt_pend_q <= 1'b0;
            adv_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            halt_pend_q <= halt_pend_d;
            adv_cnt_q   <= adv_cnt_d;
        end
    end
endmodule
